mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data bus, alongside dmem. It consumes CPU

---
 rtl/mmio_uart_tx.sv | 249 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter sitting on the CPU data
//                bus next to dmem. Stores to TXDATA queue bytes in a small
//                FIFO; a bit-serialiser drains the FIFO onto tx, LSB first.
//                STATUS is returned combinationally on ReadData.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx
);

    // ------------------------------------------------------------------------
    // Derived widths and terminal values
    // ------------------------------------------------------------------------
    localparam int unsigned c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned c_CNT_W  = c_PTR_W + 1;
    localparam int unsigned c_BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]          c_BIT_LAST  = 3'd7;

    // Serialiser states; busy is simply "not idle".
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    // bus decode
    logic                w_hit;
    logic                w_wr_data;
    logic                w_wr_stat;
    logic [31:0]         w_status;
    logic                w_unused;

    // FIFO
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]  r_count_q,  w_count_d;
    logic                r_ovf_q,    w_ovf_d;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;

    // serialiser
    state_t              r_state_q, w_state_d;
    logic [c_BAUD_W-1:0] r_baud_q,  w_baud_d;
    logic [2:0]          r_bit_q,   w_bit_d;
    logic [7:0]          r_shreg_q, w_shreg_d;
    logic                r_tx_q,    w_tx_d;
    logic                w_baud_tc;
    logic                w_busy;

    // ------------------------------------------------------------------------
    // Bus decode: 8-byte window, word select on DataAdr[2], byte lanes ignored
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit     = (DataAdr[31:3] == BASE_ADDR[31:3]);
        w_wr_data = MemWrite & w_hit & ~DataAdr[2];
        w_wr_stat = MemWrite & w_hit &  DataAdr[2];
    end

    // Address byte-lane bits and upper store-data bits carry no meaning here.
    assign w_unused = ^{DataAdr[1:0], WriteData[31:8]};

    // ------------------------------------------------------------------------
    // Read mux: STATUS at +4, TXDATA reads as zero, nothing outside window
    // ------------------------------------------------------------------------
    always_comb begin
        w_status = {27'b0, r_ovf_q, w_busy, w_full, w_empty, 1'b0};
        ReadData = 32'h0;
        if (w_hit && DataAdr[2]) begin
            ReadData = w_status;
        end
    end

    assign hit = w_hit;
    assign tx  = r_tx_q;

    // ------------------------------------------------------------------------
    // FIFO next-state: a push into a full FIFO is dropped and flags overflow,
    // even when the serialiser pops on the same edge (full is the pre-edge
    // value). Overflow is sticky until software writes STATUS with bit 4 set.
    // ------------------------------------------------------------------------
    always_comb begin
        w_full     = (r_count_q == c_CNT_FULL);
        w_empty    = (r_count_q == '0);
        w_push     = w_wr_data & ~w_full;
        w_drop     = w_wr_data &  w_full;
        w_pop      = (r_state_q == S_IDLE) & ~w_empty;

        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_ovf_d    = r_ovf_q;

        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase

        if (w_drop) begin
            w_ovf_d = 1'b1;
        end else if (w_wr_stat && WriteData[4]) begin
            w_ovf_d = 1'b0;
        end
    end

    // FIFO pointer, occupancy and overflow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr_q] <= WriteData[7:0];
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser next-state. tx is registered, so each transition computes the
    // line level of the state being entered. A byte pushed into an empty FIFO
    // is only visible here on the following edge, since pop looks at count.
    // ------------------------------------------------------------------------
    always_comb begin
        w_baud_tc = (r_baud_q == c_BAUD_LAST);
        w_busy    = (r_state_q != S_IDLE);

        w_state_d = r_state_q;
        w_baud_d  = r_baud_q;
        w_bit_d   = r_bit_q;
        w_shreg_d = r_shreg_q;
        w_tx_d    = r_tx_q;

        case (r_state_q)
            S_IDLE: begin
                w_tx_d   = 1'b1;
                w_baud_d = '0;
                if (w_pop) begin
                    w_shreg_d = r_mem[r_rd_ptr_q];
                    w_state_d = S_START;
                    w_tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (w_baud_tc) begin
                    w_baud_d  = '0;
                    w_bit_d   = 3'd0;
                    w_state_d = S_DATA;
                    w_tx_d    = r_shreg_q[0];
                end else begin
                    w_baud_d  = r_baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (w_baud_tc) begin
                    w_baud_d = '0;
                    if (r_bit_q == c_BIT_LAST) begin
                        w_state_d = S_STOP;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_d   = r_bit_q + 3'd1;
                        w_shreg_d = {1'b0, r_shreg_q[7:1]};
                        w_tx_d    = r_shreg_q[1];
                    end
                end else begin
                    w_baud_d = r_baud_q + 1'b1;
                end
            end

            S_STOP: begin
                if (w_baud_tc) begin
                    w_baud_d  = '0;
                    w_state_d = S_IDLE;
                    w_tx_d    = 1'b1;
                end else begin
                    w_baud_d  = r_baud_q + 1'b1;
                end
            end

            default: begin
                w_baud_d  = '0;
                w_state_d = S_IDLE;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    // Serialiser state, counters, shift register and registered line output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= S_IDLE;
            r_baud_q  <= '0;
            r_bit_q   <= 3'd0;
            r_shreg_q <= 8'h00;
            r_tx_q    <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shreg_q <= w_shreg_d;
            r_tx_q    <= w_tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Directed self-checking bench for mmio_uart_tx with
//                CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'hFFFF_0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] c_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] c_STAT   = 32'hFFFF_0004;
    localparam logic [31:0] c_OUTADR = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic        tx;

    int n_vec = 0;
    int n_err = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (c_BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // Hard stop in case something in the sequence never returns
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
        DataAdr   = c_OUTADR;
        WriteData = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        DataAdr = c_STAT;
        #1;
        v = ReadData;
        DataAdr = c_OUTADR;
    endtask

    // Tick until tx is seen low, at most 'bound' cycles
    task automatic wait_start(input int bound, output int waited, output logic found);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < bound) begin
            tick();
            waited++;
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    // Current sample is frame offset k0 (0 = first start-bit cycle).
    // Sample each data bit mid-cell and the stop bit mid-cell.
    task automatic rx_byte(input int k0, output logic [7:0] b);
        int pos;
        pos = k0;
        for (int i = 0; i < 8; i++) begin
            while (pos < 6 + 4 * i) begin
                tick();
                pos++;
            end
            b[i] = tx;
        end
        while (pos < 38) begin
            tick();
            pos++;
        end
        check("stop_bit", {31'b0, tx}, 32'h1);
    endtask

    initial begin
        logic [31:0] st;
        logic [7:0]  b;
        logic        found;
        int          waited;
        logic        exp_tx;
        logic [7:0]  a5;

        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = c_OUTADR;
        WriteData = 32'h0;

        // ---- 1: reset state and window decode ----
        repeat (3) tick();
        check("rst_tx", {31'b0, tx}, 32'h1);
        read_status(st);
        check("rst_status", st, 32'h2);
        DataAdr = c_OUTADR;
        #1;
        check("out_hit", {31'b0, hit}, 32'h0);
        check("out_rdata", ReadData, 32'h0);
        DataAdr = 32'hFFFF_0008;
        #1;
        check("above_hit", {31'b0, hit}, 32'h0);
        DataAdr = c_OUTADR;
        reset = 1'b1;
        tick();

        // ---- 2: single byte A5 waveform and busy window ----
        a5 = 8'hA5;
        store(c_BASE, 32'h0000_00A5);
        check("a5_lat_tx", {31'b0, tx}, 32'h1);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k < 4)       exp_tx = 1'b0;
            else if (k < 36) exp_tx = a5[(k - 4) / 4];
            else             exp_tx = 1'b1;
            check($sformatf("a5_tx_k%0d", k), {31'b0, tx}, {31'b0, exp_tx});
            read_status(st);
            check($sformatf("a5_busy_k%0d", k), {31'b0, st[3]}, 32'h1);
        end
        tick();
        read_status(st);
        check("a5_done_status", st, 32'h2);

        // ---- 3: five back-to-back stores while idle ----
        for (int i = 1; i <= 5; i++) store(c_BASE, 32'(i));
        read_status(st);
        check("b2b_status", st, 32'hC);
        rx_byte(3, b);
        check("b2b_byte1", {24'b0, b}, 32'h01);
        for (int i = 2; i <= 5; i++) begin
            wait_start(60, waited, found);
            check($sformatf("b2b_gap%0d", i), 32'(waited), 32'd3);
            rx_byte(0, b);
            check($sformatf("b2b_byte%0d", i), {24'b0, b}, 32'(i));
        end
        repeat (2) tick();
        read_status(st);
        check("b2b_done_status", st, 32'h2);

        // ---- 4: overflow while full, then clear ----
        store(c_BASE, 32'h11);
        tick();
        store(c_BASE, 32'h22);
        store(c_BASE, 32'h33);
        store(c_BASE, 32'h44);
        store(c_BASE, 32'h55);
        store(c_BASE, 32'hFF);
        read_status(st);
        check("ovf_status", st, 32'h1C);
        store(c_STAT, 32'h10);
        read_status(st);
        check("ovf_clr_status", st, 32'hC);
        rx_byte(6, b);
        check("ovf_byte11", {24'b0, b}, 32'h11);
        for (int i = 2; i <= 5; i++) begin
            wait_start(60, waited, found);
            check($sformatf("ovf_gap%0d", i), 32'(waited), 32'd3);
            rx_byte(0, b);
            check($sformatf("ovf_byte%0d", i), {24'b0, b}, 32'(i * 8'h11));
        end
        wait_start(60, waited, found);
        check("ovf_no_ff", {31'b0, found}, 32'h0);
        read_status(st);
        check("ovf_end_status", st, 32'h2);

        // ---- 5: async reset mid DATA bit 3 with two bytes queued ----
        store(c_BASE, 32'h07);
        tick();
        store(c_BASE, 32'hAA);
        store(c_BASE, 32'h55);
        repeat (15) tick();
        check("mid_tx_bit3", {31'b0, tx}, 32'h0);
        read_status(st);
        check("mid_status", st, 32'h8);
        reset = 1'b0;
        #1;
        check("rst_async_tx", {31'b0, tx}, 32'h1);
        read_status(st);
        check("rst_async_status", st, 32'h2);
        repeat (3) tick();
        reset = 1'b1;
        wait_start(60, waited, found);
        check("rst_no_frame", {31'b0, found}, 32'h0);
        read_status(st);
        check("rst_after_status", st, 32'h2);

        // ---- 6: TXDATA read, non-strobed and out-of-window stores ----
        DataAdr = c_BASE;
        #1;
        check("txdata_hit", {31'b0, hit}, 32'h1);
        check("txdata_rdata", ReadData, 32'h0);
        MemWrite  = 1'b0;
        WriteData = 32'h77;
        repeat (3) tick();
        DataAdr   = c_OUTADR;
        read_status(st);
        check("nowr_status", st, 32'h2);
        check("nowr_tx", {31'b0, tx}, 32'h1);
        store(32'h0000_0000, 32'h66);
        read_status(st);
        check("outwr_status", st, 32'h2);
        store(32'hFFFF_0002, 32'h3C);
        read_status(st);
        check("lane_status", st, 32'h0);
        wait_start(60, waited, found);
        check("lane_latency", 32'(waited), 32'd1);
        rx_byte(0, b);
        check("lane_byte", {24'b0, b}, 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
